// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control sequencer for two-operand ALU instructions
// of the form Rd <- Ri op Rj on a shared data bus.
//
// The operand indices are latched on an accepted start. The sequencer then
// drives one-hot register strobes and ALU strobes in a bus-safe order:
//   read A, settle, read B, settle, execute, write back.
// Every output is a pure decode of the registered state and latched indices.
//
// Optional feature: define ALU_SEQ_IMM_EN to add the imm_sel/imm_out_en
// ports. With imm_sel=1, operand B comes from the immediate source instead
// of register j, and src_j is not range-checked.
module alu_op_sequencer #(
  parameter int NUM_REGS   = 5,
  parameter int IDX_W      = 6,
  parameter int SETTLE_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [IDX_W-1:0]    src_i,
  input  logic [IDX_W-1:0]    src_j,
  input  logic [IDX_W-1:0]    dst,
`ifdef ALU_SEQ_IMM_EN
  input  logic                imm_sel,
  output logic                imm_out_en,
`endif
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic                alu_a_ld,
  output logic                alu_b_ld,
  output logic                alu_en,
  output logic                alu_out_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [3:0] {
    IDLE, RD_A, SET_A, RD_B, SET_B, EXEC, WB, DONE, ERR
  } state_t;

  // The settle counter counts down to zero, so a gap of N cycles loads N-1.
  localparam logic [3:0]     SETTLE_LD = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
  localparam logic [IDX_W:0] NREGS_L   = (IDX_W + 1)'(NUM_REGS);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_i, idx_j, idx_d;
  logic             bad_i, bad_j, bad_d, idx_bad;
`ifdef ALU_SEQ_IMM_EN
  logic             imm_q;
`endif

  // Convert a latched index (already range-checked) into a one-hot strobe.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    for (int k = 0; k < NUM_REGS; k++) begin
      oh[k] = (idx == IDX_W'(k));
    end
    return oh;
  endfunction

  // Range-check the incoming indices; the immediate operand skips src_j.
  always_comb begin
    bad_i = ({1'b0, src_i} >= NREGS_L);
    bad_d = ({1'b0, dst} >= NREGS_L);
`ifdef ALU_SEQ_IMM_EN
    bad_j = !imm_sel && ({1'b0, src_j} >= NREGS_L);
`else
    bad_j = ({1'b0, src_j} >= NREGS_L);
`endif
    idx_bad = bad_i | bad_j | bad_d;
  end

  // Next-state and settle-counter logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (start) state_nxt = idx_bad ? ERR : RD_A;
      RD_A: begin
        if (SETTLE_CYC == 0) begin
          state_nxt = RD_B;
        end else begin
          state_nxt = SET_A;
          cnt_nxt   = SETTLE_LD;
        end
      end
      SET_A: begin
        if (cnt == 4'd0) state_nxt = RD_B;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RD_B: begin
        if (SETTLE_CYC == 0) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = SET_B;
          cnt_nxt   = SETTLE_LD;
        end
      end
      SET_B: begin
        if (cnt == 4'd0) state_nxt = EXEC;
        else             cnt_nxt   = cnt - 4'd1;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  // State, counter and operand-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx_i <= '0;
      idx_j <= '0;
      idx_d <= '0;
`ifdef ALU_SEQ_IMM_EN
      imm_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start && !abort) begin
        idx_i <= src_i;
        idx_j <= src_j;
        idx_d <= dst;
`ifdef ALU_SEQ_IMM_EN
        imm_q <= imm_sel;
`endif
      end
    end
  end

  // Output decode of the registered state; everything is low in IDLE.
  always_comb begin
    reg_out_en = '0;
    reg_in_en  = '0;
    alu_a_ld   = 1'b0;
    alu_b_ld   = 1'b0;
    alu_en     = 1'b0;
    alu_out_en = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    err        = 1'b0;
`ifdef ALU_SEQ_IMM_EN
    imm_out_en = 1'b0;
`endif
    case (state)
      RD_A: begin
        reg_out_en = onehot(idx_i);
        alu_a_ld   = 1'b1;
      end
      RD_B: begin
`ifdef ALU_SEQ_IMM_EN
        if (imm_q) imm_out_en = 1'b1;
        else       reg_out_en = onehot(idx_j);
`else
        reg_out_en = onehot(idx_j);
`endif
        alu_b_ld = 1'b1;
      end
      EXEC: alu_en = 1'b1;
      WB: begin
        alu_out_en = 1'b1;
        reg_in_en  = onehot(idx_d);
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer: a default instance (SETTLE_CYC=1)
// and a zero-settle instance, checked cycle by cycle against hand-computed
// strobe patterns.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Flag fields, packed as {a_ld, b_ld, alu_en, out_en, busy, done, err}.
  localparam logic [6:0] F_IDLE = 7'b0000000;
  localparam logic [6:0] F_RDA  = 7'b1000100;
  localparam logic [6:0] F_SET  = 7'b0000100;
  localparam logic [6:0] F_RDB  = 7'b0100100;
  localparam logic [6:0] F_EXEC = 7'b0010100;
  localparam logic [6:0] F_WB   = 7'b0001100;
  localparam logic [6:0] F_DONE = 7'b0000110;
  localparam logic [6:0] F_ERR  = 7'b0000101;

  int errors = 0;
  int checks = 0;

  // Default instance
  logic       rst, start, abort;
  logic [5:0] src_i, src_j, dst;
  logic [4:0] reg_out_en, reg_in_en;
  logic       alu_a_ld, alu_b_ld, alu_en, alu_out_en, busy, done, err;
  logic       imm_sel, imm_out_en;

  // Zero-settle instance
  logic       start0;
  logic [5:0] src_i0, src_j0, dst0;
  logic [4:0] reg_out_en0, reg_in_en0;
  logic       alu_a_ld0, alu_b_ld0, alu_en0, alu_out_en0, busy0, done0, err0;
  logic       imm_sel0, imm_out_en0;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_i(src_i), .src_j(src_j), .dst(dst),
`ifdef ALU_SEQ_IMM_EN
    .imm_sel(imm_sel), .imm_out_en(imm_out_en),
`endif
    .reg_out_en(reg_out_en), .reg_in_en(reg_in_en),
    .alu_a_ld(alu_a_ld), .alu_b_ld(alu_b_ld), .alu_en(alu_en),
    .alu_out_en(alu_out_en), .busy(busy), .done(done), .err(err)
  );

  alu_op_sequencer #(.NUM_REGS(5), .IDX_W(6), .SETTLE_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(1'b0),
    .src_i(src_i0), .src_j(src_j0), .dst(dst0),
`ifdef ALU_SEQ_IMM_EN
    .imm_sel(imm_sel0), .imm_out_en(imm_out_en0),
`endif
    .reg_out_en(reg_out_en0), .reg_in_en(reg_in_en0),
    .alu_a_ld(alu_a_ld0), .alu_b_ld(alu_b_ld0), .alu_en(alu_en0),
    .alu_out_en(alu_out_en0), .busy(busy0), .done(done0), .err(err0)
  );

`ifndef ALU_SEQ_IMM_EN
  assign imm_out_en  = 1'b0;
  assign imm_out_en0 = 1'b0;
`endif

  logic [17:0] obs, obs0;
  assign obs  = {imm_out_en, reg_out_en, reg_in_en,
                 alu_a_ld, alu_b_ld, alu_en, alu_out_en, busy, done, err};
  assign obs0 = {imm_out_en0, reg_out_en0, reg_in_en0,
                 alu_a_ld0, alu_b_ld0, alu_en0, alu_out_en0, busy0, done0, err0};

  function automatic logic [17:0] ex(input logic [4:0] ro, input logic [4:0] ri,
                                     input logic [6:0] f, input logic imm);
    return {imm, ro, ri, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; imm_sel = 1'b0;
    src_i = '0; src_j = '0; dst = '0;
    start0 = 1'b0; src_i0 = '0; src_j0 = '0; dst0 = '0; imm_sel0 = 1'b0;
    step(); step();
    chk("reset_dut", obs, '0);
    chk("reset_dut0", obs0, '0);
    rst = 1'b0;
    step();
    chk("idle_after_reset", obs, '0);

    // Default op i=1, j=2, d=1
    src_i = 6'd1; src_j = 6'd2; dst = 6'd1; start = 1'b1;
    step(); start = 1'b0;
    chk("op1_c1_rda", obs, ex(5'b00010, 5'b0, F_RDA, 1'b0));
    step(); chk("op1_c2_seta", obs, ex(5'b0, 5'b0, F_SET, 1'b0));
    step(); chk("op1_c3_rdb", obs, ex(5'b00100, 5'b0, F_RDB, 1'b0));
    step(); chk("op1_c4_setb", obs, ex(5'b0, 5'b0, F_SET, 1'b0));
    step(); chk("op1_c5_exec", obs, ex(5'b0, 5'b0, F_EXEC, 1'b0));
    step(); chk("op1_c6_wb", obs, ex(5'b0, 5'b00010, F_WB, 1'b0));
    step(); chk("op1_c7_done", obs, ex(5'b0, 5'b0, F_DONE, 1'b0));
    // start raised in the DONE cycle must be ignored
    start = 1'b1;
    step(); chk("start_in_done_ignored", obs, '0);
    // still high in IDLE: accepted now
    step(); chk("start_after_done_rda", obs, ex(5'b00010, 5'b0, F_RDA, 1'b0));
    start = 1'b0; abort = 1'b1;
    step(); chk("abort_in_rda", obs, '0);
    abort = 1'b0;
    step(); chk("abort_stays_idle", obs, '0);

    // Zero settle, i=j=d=4
    src_i0 = 6'd4; src_j0 = 6'd4; dst0 = 6'd4; start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("s0_c1_rda", obs0, ex(5'b10000, 5'b0, F_RDA, 1'b0));
    step(); chk("s0_c2_rdb", obs0, ex(5'b10000, 5'b0, F_RDB, 1'b0));
    step(); chk("s0_c3_exec", obs0, ex(5'b0, 5'b0, F_EXEC, 1'b0));
    step(); chk("s0_c4_wb", obs0, ex(5'b0, 5'b10000, F_WB, 1'b0));
    step(); chk("s0_c5_done", obs0, ex(5'b0, 5'b0, F_DONE, 1'b0));
    step(); chk("s0_c6_idle", obs0, '0);

    // Invalid j=5
    src_i = 6'd0; src_j = 6'd5; dst = 6'd2; start = 1'b1;
    step(); start = 1'b0;
    chk("bad_j_err", obs, ex(5'b0, 5'b0, F_ERR, 1'b0));
    step(); chk("bad_j_idle", obs, '0);
    // Invalid d=63
    src_j = 6'd3; dst = 6'd63; start = 1'b1;
    step(); start = 1'b0;
    chk("bad_d_err", obs, ex(5'b0, 5'b0, F_ERR, 1'b0));
    step(); chk("bad_d_idle", obs, '0);
    // Following valid op i=0, j=3, d=2
    dst = 6'd2; start = 1'b1;
    step(); start = 1'b0;
    chk("op2_c1_rda", obs, ex(5'b00001, 5'b0, F_RDA, 1'b0));
    step(); chk("op2_c2_seta", obs, ex(5'b0, 5'b0, F_SET, 1'b0));
    step(); chk("op2_c3_rdb", obs, ex(5'b01000, 5'b0, F_RDB, 1'b0));
    step(); step(); step();
    chk("op2_c6_wb", obs, ex(5'b0, 5'b00100, F_WB, 1'b0));
    step(); chk("op2_c7_done", obs, ex(5'b0, 5'b0, F_DONE, 1'b0));
    step(); chk("op2_c8_idle", obs, '0);

    // Abort in cycle 4 with start held high throughout; index change ignored
    src_i = 6'd1; src_j = 6'd2; dst = 6'd3; start = 1'b1;
    step(); src_i = 6'd4; src_j = 6'd4;
    chk("ab_c1_rda", obs, ex(5'b00010, 5'b0, F_RDA, 1'b0));
    step(); chk("ab_c2_seta", obs, ex(5'b0, 5'b0, F_SET, 1'b0));
    step(); chk("ab_c3_rdb_held_start", obs, ex(5'b00100, 5'b0, F_RDB, 1'b0));
    step(); chk("ab_c4_setb", obs, ex(5'b0, 5'b0, F_SET, 1'b0));
    abort = 1'b1;
    step(); chk("ab_c5_zero", obs, '0);
    abort = 1'b0; start = 1'b0;
    step(); chk("ab_c6_no_done", obs, '0);
    // abort and start together in IDLE: abort wins
    src_i = 6'd1; src_j = 6'd2; dst = 6'd1; start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", obs, '0);
    step(); chk("abort_beats_start_c2", obs, '0);

    // rst pulsed in WB
    start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); step(); step();
    chk("rst_pre_wb", obs, ex(5'b0, 5'b00010, F_WB, 1'b0));
    rst = 1'b1;
    step(); chk("rst_in_wb", obs, '0);
    // rst has priority over start
    start = 1'b1;
    step(); rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", obs, '0);
    step(); chk("rst_idle_after", obs, '0);

`ifdef ALU_SEQ_IMM_EN
    // Immediate operand B, j out of range must not raise err
    src_i = 6'd2; src_j = 6'd63; dst = 6'd3; imm_sel = 1'b1; start = 1'b1;
    step(); start = 1'b0; imm_sel = 1'b0;
    chk("imm_c1_rda", obs, ex(5'b00100, 5'b0, F_RDA, 1'b0));
    step(); chk("imm_c2_seta", obs, ex(5'b0, 5'b0, F_SET, 1'b0));
    step(); chk("imm_c3_rdb", obs, ex(5'b0, 5'b0, F_RDB, 1'b1));
    step(); step(); step();
    chk("imm_c6_wb", obs, ex(5'b0, 5'b01000, F_WB, 1'b0));
    step(); chk("imm_c7_done", obs, ex(5'b0, 5'b0, F_DONE, 1'b0));
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised control sequencer for two-operand ALU instructions of the form Rd <- Ri op Rj on the shared data bus. Sits between the instruction decoder and the register file / ALU datapath; it latches operand indices on a start pulse, then drives one-hot register read/write strobes and ALU load/execute strobes in a fixed bus-safe order. Supports any register count, configurable bus-settle gaps, abort, and invalid-index detection.

## Interface
- NUM_REGS, 5, number of addressable registers (index 0..NUM_REGS-1; default maps R0-R3, P0)
- IDX_W, 6, width of register index fields
- SETTLE_CYC, 1, idle bus cycles inserted after each operand read (0..15; 0 removes settle states)

- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel (fetch restart); returns to IDLE
- src_i  in  IDX_W  operand A register index, latched on accepted start
- src_j  in  IDX_W  operand B register index, latched on accepted start
- dst  in  IDX_W  destination register index, latched on accepted start
- reg_out_en  out  NUM_REGS  one-hot register-to-bus enable
- reg_in_en  out  NUM_REGS  one-hot bus-to-register load
- alu_a_ld  out  1  ALU operand A latch
- alu_b_ld  out  1  ALU operand B latch
- alu_en  out  1  ALU result register enable
- alu_out_en  out  1  ALU result to bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle invalid-index pulse

## Operation
- States: IDLE, RD_A, SET_A, RD_B, SET_B, EXEC, WB, DONE, ERR.
- IDLE: start=1 latches src_i/src_j/dst; any index >= NUM_REGS -> ERR, else -> RD_A.
- RD_A: reg_out_en[i]=1, alu_a_ld=1; -> SET_A (or RD_B if SETTLE_CYC=0).
- SET_A: all strobes low for SETTLE_CYC cycles (down-counter, reloaded on entry); -> RD_B.
- RD_B: reg_out_en[j]=1, alu_b_ld=1; -> SET_B (or EXEC if SETTLE_CYC=0).
- SET_B: as SET_A; -> EXEC.
- EXEC: alu_en=1; -> WB.
- WB: alu_out_en=1, reg_in_en[d]=1; -> DONE.
- DONE: done=1; -> IDLE. ERR: err=1, no register/ALU strobe; -> IDLE.
- At most one bit of reg_out_en set in any cycle; reg_out_en and alu_out_en never high together.
- i==j permitted: same bit asserted in RD_A and RD_B. d may equal i or j.
- Outputs are pure decodes of registered state and latched indices; all zero in IDLE.

## Timing
- Reset: state IDLE, latched indices 0, settle counter 0; every output 0 in the cycle after rst sampled high.
- Latency: start accepted at edge 0 -> done high in cycle 5 + 2*SETTLE_CYC (7 for default); busy high from cycle 1 through done cycle.
- start while busy ignored (no queueing); start in DONE cycle ignored, next request accepted in IDLE.
- Invalid index: err high in cycle 1, busy high that cycle only, back in IDLE at cycle 2.
- abort=1 in any state: IDLE at next edge, outputs 0, no done/err. abort and start in same IDLE cycle: abort wins, request dropped.
- rst has priority over abort and start.

## Configuration
- ALU_SEQ_IMM_EN defined: adds input imm_sel (1) and output imm_out_en (1). imm_sel latched with start; when 1, RD_B asserts imm_out_en instead of reg_out_en[j], and src_j is excluded from the range check. imm_out_en reset value 0.
- Undefined: ports absent; all operations register-register; src_j always range-checked.

## Test plan
- Default params, start with i=1, j=2, d=1 -> reg_out_en=00010 + alu_a_ld at cycle 1, reg_out_en=00100 + alu_b_ld at cycle 3, alu_en cycle 5, reg_in_en=00010 + alu_out_en cycle 6, done cycle 7.
- SETTLE_CYC=0, i=j=d=4 -> reg_out_en=10000 cycles 1 and 2, alu_en cycle 3, reg_in_en=10000 cycle 4, done cycle 5.
- start with j=5 (NUM_REGS=5) -> err pulse cycle 1, no strobes, busy low cycle 2; following valid start completes normally.
- abort asserted in cycle 4 of a default op -> all outputs 0 from cycle 5, no done; start held high during busy cycles ignored.
- rst pulsed in WB -> reg_in_en/alu_out_en low next cycle, IDLE; with ALU_SEQ_IMM_EN and imm_sel=1, j=63 -> no err, imm_out_en=1 with alu_b_ld in cycle 3.
